// File: rtl/uart_tx_scheduler_if.sv
// Bundle between byte requesters, the scheduler and the shared UART transmitter.
// The slave modport is the scheduler; the master side holds the requesters and the transmitter.
interface uart_tx_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_en;
  logic                          tx_busy;
  logic [IdW-1:0]                grant_id;
  logic                          grant_lock;
  logic                          tx_err;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_en, grant_id, grant_lock, tx_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_en, grant_id, grant_lock, tx_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers,
// with optional packet grant lock, start timeout and a post-frame idle gap.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned GAP_CLOCKS    = 0,
  parameter int unsigned START_TIMEOUT = 4
) (
  input logic                clk,
  input logic                rstn,
  uart_tx_scheduler_if.slave io_bus
);
  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned CntMax = (GAP_CLOCKS > START_TIMEOUT) ? GAP_CLOCKS : START_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  state_e                r_state;
  logic [IdW-1:0]        r_rr_ptr;
  logic [IdW-1:0]        r_grant_id;
  logic                  r_grant_lock;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [CntW-1:0]       r_cnt;

  state_e                w_state_d;
  logic [IdW-1:0]        w_rr_ptr_d;
  logic [IdW-1:0]        w_grant_id_d;
  logic                  w_grant_lock_d;
  logic [DATA_WIDTH-1:0] w_tx_data_d;
  logic [CntW-1:0]       w_cnt_d;

  logic [DATA_WIDTH-1:0] w_req_byte [NUM_REQ];
  logic [IdW-1:0]        w_scan_idx;
  logic [IdW-1:0]        w_winner;
  logic                  w_found;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_tx_en;
  logic                  w_tx_err;

  function automatic logic [IdW-1:0] next_idx(input logic [IdW-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_byte[g] = io_bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // A held lock restricts eligibility to the current owner; otherwise scan from rr_ptr.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = r_grant_id;
    w_scan_idx = '0;
    if (r_grant_lock) begin
      w_found = io_bus.req_valid[r_grant_id];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        w_scan_idx = IdW'((32'(r_rr_ptr) + i) % NUM_REQ);
        if (!w_found && io_bus.req_valid[w_scan_idx]) begin
          w_found  = 1'b1;
          w_winner = w_scan_idx;
        end
      end
    end
  end

  assign w_accept = (r_state == StIdle) && w_found;

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_rr_ptr_d     = r_rr_ptr;
    w_grant_id_d   = r_grant_id;
    w_grant_lock_d = r_grant_lock;
    w_tx_data_d    = r_tx_data;
    w_cnt_d        = r_cnt;
    w_tx_en        = 1'b0;
    w_tx_err       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_tx_data_d    = w_req_byte[w_winner];
          w_grant_id_d   = w_winner;
          w_grant_lock_d = ~io_bus.req_last[w_winner];
          if (io_bus.req_last[w_winner]) begin
            w_rr_ptr_d = next_idx(w_winner);
          end
          w_state_d = StLaunch;
        end
      end
      StLaunch: begin
        w_tx_en   = 1'b1;
        w_cnt_d   = '0;
        w_state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (io_bus.tx_busy) begin
          w_state_d = StWaitDone;
        end else if (r_cnt == CntW'(START_TIMEOUT)) begin
          // Transmitter never started: drop the byte and release the grant.
          w_tx_err       = 1'b1;
          w_grant_lock_d = 1'b0;
          w_rr_ptr_d     = next_idx(r_grant_id);
          w_cnt_d        = '0;
          w_state_d      = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StWaitDone: begin
        if (!io_bus.tx_busy) begin
          if (GAP_CLOCKS == 0) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d   = CntW'(GAP_CLOCKS);
            w_state_d = StGap;
          end
        end
      end
      StGap: begin
        if (r_cnt <= CntW'(1)) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= StIdle;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_grant_lock <= 1'b0;
      r_tx_data    <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_rr_ptr     <= w_rr_ptr_d;
      r_grant_id   <= w_grant_id_d;
      r_grant_lock <= w_grant_lock_d;
      r_tx_data    <= w_tx_data_d;
      r_cnt        <= w_cnt_d;
    end
  end

  assign io_bus.req_ready  = w_ready;
  assign io_bus.tx_data    = r_tx_data;
  assign io_bus.tx_en      = w_tx_en;
  assign io_bus.grant_id   = r_grant_id;
  assign io_bus.grant_lock = r_grant_lock;
  assign io_bus.tx_err     = w_tx_err;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench: two schedulers (gap 0 and gap 5) against a transaction-level model
// that predicts grants, launches, timeouts and earliest re-arbitration times.
module tb_uart_tx_scheduler;
  localparam int unsigned NR   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned ST   = 4;
  localparam int          NCYC = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned Gap = (g == 0) ? 0 : 5;

    logic       rstn;
    logic [3:0] stub_len;
    logic       stub_dead;
    int         tx_cnt;

    uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_scheduler #(
      .NUM_REQ      (NR),
      .DATA_WIDTH   (DW),
      .GAP_CLOCKS   (Gap),
      .START_TIMEOUT(ST)
    ) dut (
      .clk   (clk),
      .rstn  (rstn),
      .io_bus(bus)
    );

    // Transmitter stand-in: busy for stub_len clocks after sampling tx_en, or never if dead.
    always @(posedge clk or negedge rstn) begin
      if (!rstn) tx_cnt <= 0;
      else if (bus.tx_en && !stub_dead) tx_cnt <= int'(stub_len);
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.tx_busy = (tx_cnt != 0);

    initial begin : model
      logic [DW:0]     fifo [NR][16];
      int              head [NR];
      int              tail [NR];
      int              idle_from, en_at, err_at, clear_at;
      int              m_rr, m_gid, w, rate;
      logic            m_lock, last, did_rst;
      logic [DW-1:0]   m_data;

      for (int i = 0; i < NR; i++) begin
        head[i] = 0;
        tail[i] = 0;
        for (int j = 0; j < 16; j++) fifo[i][j] = '0;
      end
      rstn          = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      stub_len      = 4'd1;
      stub_dead     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_tx_en", 32'(bus.tx_en), 0);
      check_eq("reset_tx_data", 32'(bus.tx_data), 0);
      check_eq("reset_grant_id", 32'(bus.grant_id), 0);
      check_eq("reset_grant_lock", 32'(bus.grant_lock), 0);
      check_eq("reset_tx_err", 32'(bus.tx_err), 0);
      @(negedge clk);
      rstn      = 1'b1;
      m_rr      = 0;
      m_gid     = 0;
      m_lock    = 1'b0;
      m_data    = '0;
      idle_from = 0;
      en_at     = -1;
      err_at    = -1;
      clear_at  = -1;
      did_rst   = 1'b0;

      for (int n = 0; n < NCYC; n++) begin
        @(negedge clk);
        if (n == clear_at) begin
          m_lock = 1'b0;
          m_rr   = (m_gid + 1) % NR;
        end
        // Alternate light and heavy offered load.
        rate = ((n / 250) % 2 == 1) ? 1 : 9;
        for (int i = 0; i < NR; i++) begin
          if (tail[i] - head[i] < 8 && $urandom_range(rate) == 0) begin
            fifo[i][tail[i] % 16] = {($urandom_range(2) != 0), DW'($urandom)};
            tail[i]++;
          end
        end

        if (!did_rst && n >= NCYC / 2 && n > en_at && n + 1 < idle_from) begin
          rstn          = 1'b0;
          bus.req_valid = '0;
          #1;
          check_eq("midrst_tx_en", 32'(bus.tx_en), 0);
          check_eq("midrst_grant_lock", 32'(bus.grant_lock), 0);
          check_eq("midrst_grant_id", 32'(bus.grant_id), 0);
          check_eq("midrst_tx_data", 32'(bus.tx_data), 0);
          check_eq("midrst_req_ready", 32'(bus.req_ready), 0);
          @(negedge clk);
          rstn      = 1'b1;
          did_rst   = 1'b1;
          m_rr      = 0;
          m_gid     = 0;
          m_lock    = 1'b0;
          m_data    = '0;
          idle_from = 0;
          en_at     = -1;
          err_at    = -1;
          clear_at  = -1;
          continue;
        end

        for (int i = 0; i < NR; i++) begin
          bus.req_valid[i]         = (tail[i] != head[i]);
          bus.req_data[i*DW +: DW] = fifo[i][head[i] % 16][DW-1:0];
          bus.req_last[i]          = fifo[i][head[i] % 16][DW];
        end
        #1;
        check_eq("tx_en", 32'(bus.tx_en), 32'(n == en_at));
        check_eq("tx_err", 32'(bus.tx_err), 32'(n == err_at));
        check_eq("tx_data", 32'(bus.tx_data), 32'(m_data));
        check_eq("grant_id", 32'(bus.grant_id), 32'(m_gid));
        check_eq("grant_lock", 32'(bus.grant_lock), 32'(m_lock));

        w = -1;
        if (n >= idle_from) begin
          if (m_lock) begin
            if (tail[m_gid] != head[m_gid]) w = m_gid;
          end else begin
            for (int k = 0; k < NR; k++) begin
              if (w < 0 && tail[(m_rr + k) % NR] != head[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            end
          end
        end
        check_eq("req_ready", 32'(bus.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);

        if (w >= 0) begin
          m_data = fifo[w][head[w] % 16][DW-1:0];
          last   = fifo[w][head[w] % 16][DW];
          head[w]++;
          m_gid  = w;
          m_lock = !last;
          if (last) m_rr = (w + 1) % NR;
          en_at     = n + 1;
          stub_dead = ($urandom_range(7) == 0);
          stub_len  = 4'($urandom_range(6, 1));
          if (stub_dead) begin
            err_at    = n + 2 + ST;
            clear_at  = n + 3 + ST;
            idle_from = n + 3 + ST;
          end else begin
            idle_from = n + int'(stub_len) + 3 + Gap;
          end
        end
      end
      bus.req_valid = '0;
      n_done++;
    end
  end

  initial begin
    for (int t = 0; t < 3 * NCYC + 100 && n_done < 2; t++) @(negedge clk);
    check_eq("run_bound", 32'(n_done), 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART `transmitter` between `NUM_REQ` byte producers on the system bus side. Each requester offers bytes over a valid/ready handshake. The scheduler launches one byte at a time into the transmitter with a single-cycle `data_en` pulse and tracks `tx_busy` to frame completion. It optionally locks the grant for a multi-byte packet and inserts a programmable idle gap between frames.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 8: byte width; must match the transmitter.
- `GAP_CLOCKS`, 0: idle clocks inserted after each frame before re-arbitration (0–255).
- `START_TIMEOUT`, 4: clocks to wait for `tx_busy` to rise after launch (≥2).

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` in `NUM_REQ`: byte is the last of a packet; 0 requests grant lock.
- `req_ready` out `NUM_REQ`: byte accepted when valid&ready on a rising edge.
- `tx_data` out `DATA_WIDTH`: to transmitter `data_in`.
- `tx_en` out 1: to transmitter `data_en`.
- `tx_busy` in 1: from transmitter `tx_busy`.
- `grant_id` out `$clog2(NUM_REQ)`: requester owning the current/last byte.
- `grant_lock` out 1: packet lock held.
- `tx_err` out 1: one-cycle pulse, start timeout.

## Operation
- States: S_IDLE (arbitrate), S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_GAP. Reset state S_IDLE.
- S_IDLE arbitration:
  - Winner is the first asserted `req_valid` at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - If `grant_lock`=1, only `grant_id` is eligible.
  - `req_ready` is combinational: one-hot on the winner only in S_IDLE and only when the winner's `req_valid`=1; all zero otherwise.
- On accept:
  - Register `tx_data` ← winner byte and `grant_id` ← winner.
  - `grant_lock` ← ~`req_last[winner]`.
  - If `req_last`=1, `rr_ptr` ← winner+1 (wrap). Otherwise `rr_ptr` is unchanged.
  - Next state S_LAUNCH.
- S_LAUNCH: `tx_en`=1 for exactly this cycle → S_WAIT_BUSY with timeout counter cleared.
- S_WAIT_BUSY:
  - `tx_busy`=1 → S_WAIT_DONE.
  - Otherwise count. At `START_TIMEOUT` clocks: pulse `tx_err`, drop the byte, clear `grant_lock`, advance `rr_ptr` to `grant_id`+1 → S_IDLE.
- S_WAIT_DONE: `tx_busy`=0 → S_GAP with counter loaded to `GAP_CLOCKS`, or directly to S_IDLE if `GAP_CLOCKS`=0.
- S_GAP: decrement each cycle; at 1 → S_IDLE.
- `tx_data` holds its value from accept until the next accept; it does not change during a frame.
- No `req_valid` in S_IDLE: remain in S_IDLE; a held lock persists indefinitely.
- Reset values: `tx_en`=0, `tx_data`=0, `grant_id`=0, `grant_lock`=0, `tx_err`=0, `rr_ptr`=0, counters 0.
- `req_ready` is combinational from the S_IDLE state; requesters keep `req_valid`=0 while `rstn` is low.
- Reset mid-frame returns all state immediately. The transmitter is reset by the same `rstn`.

## Timing
- Accept at edge T. `tx_en`=1 in cycle T+1. Transmitter samples it at edge T+2, and `tx_busy`=1 from T+2.
- Frame end: `tx_busy` sampled 0 at edge E.
  - With `GAP_CLOCKS`=0, S_IDLE is entered at E and the earliest next accept is at edge E+1.
  - With gap G, the earliest next accept is at edge E+G+1.
- Byte-to-byte throughput = frame length + 3 + `GAP_CLOCKS` clocks.
- Simultaneous valids: exactly one ready per accept. After each packet ends, priority rotates to the next index.
- `tx_err` asserts in the cycle S_WAIT_BUSY reaches timeout; `tx_en` is never re-pulsed for a dropped byte.

## Test plan
- Single requester 2, byte 0xA5, `req_last`=1, real transmitter with CLOCKS_PER_PULSE=4:
  - `req_ready[2]` high one cycle, then `tx_en` one-cycle pulse.
  - Serial line shows 0xA5 LSB first.
  - `rr_ptr` becomes 3 and `grant_lock`=0 throughout.
- All four requesters valid continuously, each byte `last`=1, bytes 0x10..0x13 → transmit order 0,1,2,3,0.
- Requester 1 sends a 3-byte packet (0x01,0x02 with `last`=0; 0x03 with `last`=1) while requester 0 stays valid:
  - Bytes 0x01,0x02,0x03 are contiguous with `grant_lock`=1 until 0x03 is accepted.
  - Requester 0 is served next.
- `GAP_CLOCKS`=5, two queued bytes → measure exactly 6 cycles from `tx_busy` sampled low to the next `req_ready`.
- Stub transmitter holds `tx_busy`=0 → `tx_err` pulses 4 cycles after S_WAIT_BUSY entry, `tx_en` pulsed only once, and the scheduler re-arbitrates.
- Assert `rstn` low mid-frame → `tx_en`=0, `grant_lock`=0, `grant_id`=0. After release, first accept goes to the lowest-index valid requester.
